// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the ctrl_pipe control-word pipeline.
// The optional MDU sequencer is enabled by defining CTRL_PIPE_MDU_EN.
package ctrl_pipe_pkg;

   localparam int CW_DEF = 12;

   localparam int STG_E = 0;
   localparam int STG_M = 1;
   localparam int STG_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: flush, hold, bubble insertion or load from upstream.
// Used by ctrl_pipe for every stage; the MDU flag is carried whether or not CTRL_PIPE_MDU_EN is set.
module ctrl_stage_reg
   import ctrl_pipe_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          hold,
   input  logic          bubble,
   input  logic [CW-1:0] src_ctrl,
   input  logic          src_valid,
   input  logic          src_mdu,
   output logic [CW-1:0] ctrl,
   output logic          valid,
   output logic          mdu
);

   // NOTE: state registers use non-blocking assignments so every stage samples
   // its neighbour's pre-edge value; blocking here would collapse the pipeline.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ctrl  <= '0;
         valid <= 1'b0;
         mdu   <= 1'b0;
      end else if (!hold) begin
         // An invalid source is a bubble too, so junk control never travels.
         if (bubble || !src_valid) begin
            ctrl  <= '0;
            valid <= 1'b0;
            mdu   <= 1'b0;
         end else begin
            ctrl  <= src_ctrl;
            valid <= 1'b1;
            mdu   <= src_mdu;
         end
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline D -> E..W with per-stage stall/flush and upstream hold propagation.
// Define CTRL_PIPE_MDU_EN to build the MDU sequencer that pins mult/div ops in E for MDU_LAT cycles.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int CW      = CW_DEF,
   parameter int STAGES  = 3,
   parameter int MDU_LAT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CW-1:0]        ctrlD,
   input  logic                 validD,
   input  logic                 mduD,
   input  logic [STAGES-1:0]    stall,
   input  logic [STAGES-1:0]    flush,
   output logic [STAGES*CW-1:0] ctrl_o,
   output logic [STAGES-1:0]    valid_o,
   output logic                 stall_req,
   output logic                 mdu_start,
   output logic                 mdu_busy
);

   logic [CW-1:0]     ctrl_q [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] mdu_q;
   logic [STAGES:0]   hold;
   logic              mdu_stall;
   logic              mdu_src;
   logic              unused_tail;

   // A stalled stage freezes everything upstream of it.
   always_comb begin
      hold = '0;
      for (int s = STAGES - 1; s >= 0; s--) hold[s] = stall[s] | hold[s+1];
      hold[STG_E] = hold[STG_E] | mdu_stall;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [CW-1:0] src_ctrl;
      logic          src_valid;
      logic          src_mdu;
      logic          bubble;

      if (s == 0) begin : g_head
         assign src_ctrl  = ctrlD;
         assign src_valid = validD;
         assign src_mdu   = mdu_src;
         assign bubble    = 1'b0;
      end else begin : g_body
         assign src_ctrl  = ctrl_q[s-1];
         assign src_valid = valid_q[s-1];
         assign src_mdu   = mdu_q[s-1];
         assign bubble    = hold[s-1];
      end

      ctrl_stage_reg #(.CW(CW)) u_reg (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush[s]),
         .hold      (hold[s]),
         .bubble    (bubble),
         .src_ctrl  (src_ctrl),
         .src_valid (src_valid),
         .src_mdu   (src_mdu),
         .ctrl      (ctrl_q[s]),
         .valid     (valid_q[s]),
         .mdu       (mdu_q[s])
      );

      assign ctrl_o[s*CW +: CW] = ctrl_q[s];
   end

   assign valid_o     = valid_q;
   assign stall_req   = hold[STG_E];
   assign unused_tail = mdu_q[STAGES-1];

`ifdef CTRL_PIPE_MDU_EN
   localparam int CNT_W      = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
   localparam int CNT_INIT_I = (MDU_LAT > 1) ? MDU_LAT - 2 : 0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);
   localparam bit MULTI = (MDU_LAT > 1);

   mdu_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             mdu_op;

   assign mdu_src   = mduD;
   assign mdu_op    = valid_q[STG_E] & mdu_q[STG_E];
   assign mdu_stall = mdu_op && MULTI && (state == IDLE || (state == BUSY && cnt != '0));
   assign mdu_busy  = (state == BUSY);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      mdu_start = 1'b0;
      case (state)
         IDLE: begin
            if (mdu_op) begin
               mdu_start = 1'b1;
               if (MULTI) begin
                  state_nx = BUSY;
                  cnt_nx   = CNT_INIT;
               end else if (hold[STG_E]) begin
                  // Single-cycle op held externally: park so start does not re-fire.
                  state_nx = DONE;
               end
            end
         end
         BUSY: begin
            if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
            else           state_nx = hold[STG_E] ? DONE : IDLE;
         end
         DONE: begin
            if (!hold[STG_E]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush[STG_E]) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end
   end
`else
   logic unused_mdu;

   assign unused_mdu = mduD;
   assign mdu_src    = 1'b0;
   assign mdu_stall  = 1'b0;
   assign mdu_start  = 1'b0;
   assign mdu_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed test-plan steps followed by random traffic,
// all compared against an occupancy/age model; follows CTRL_PIPE_MDU_EN when it is defined.
module tb_ctrl_pipe;
   import ctrl_pipe_pkg::*;

   localparam int CW      = CW_DEF;
   localparam int STAGES  = 3;
   localparam int MDU_LAT = 4;
`ifdef CTRL_PIPE_MDU_EN
   localparam bit MDU_EN = 1'b1;
`else
   localparam bit MDU_EN = 1'b0;
`endif

   logic                 clk;
   logic                 reset;
   logic [CW-1:0]        ctrlD;
   logic                 validD;
   logic                 mduD;
   logic [STAGES-1:0]    stall;
   logic [STAGES-1:0]    flush;
   logic [STAGES*CW-1:0] ctrl_o;
   logic [STAGES-1:0]    valid_o;
   logic                 stall_req;
   logic                 mdu_start;
   logic                 mdu_busy;

   ctrl_pipe #(.CW(CW), .STAGES(STAGES), .MDU_LAT(MDU_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .ctrlD     (ctrlD),
      .validD    (validD),
      .mduD      (mduD),
      .stall     (stall),
      .flush     (flush),
      .ctrl_o    (ctrl_o),
      .valid_o   (valid_o),
      .stall_req (stall_req),
      .mdu_start (mdu_start),
      .mdu_busy  (mdu_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: what each stage holds, plus how long the current E occupant has sat in E.
   logic [CW-1:0]   m_ctrl  [STAGES];
   logic            m_valid [STAGES];
   logic            m_mdu   [STAGES];
   int              age;
   logic [STAGES:0] m_hold;
   logic            m_mstall;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_comb();
      m_mstall = MDU_EN && m_valid[0] && m_mdu[0] && (MDU_LAT > 1) && (age < MDU_LAT - 1);
      m_hold = '0;
      for (int s = STAGES - 1; s >= 0; s--) m_hold[s] = stall[s] | m_hold[s+1];
      m_hold[0] = m_hold[0] | m_mstall;
   endtask

   task automatic model_edge();
      logic [CW-1:0] nc [STAGES];
      logic          nv [STAGES];
      logic          nm [STAGES];
      for (int s = 0; s < STAGES; s++) begin
         nc[s] = m_ctrl[s];
         nv[s] = m_valid[s];
         nm[s] = m_mdu[s];
         if (reset || flush[s]) begin
            nc[s] = '0; nv[s] = 1'b0; nm[s] = 1'b0;
         end else if (m_hold[s]) begin
            // contents stay put
         end else if (s == 0) begin
            nv[s] = validD;
            nc[s] = validD ? ctrlD : '0;
            nm[s] = validD & mduD & MDU_EN;
         end else if (m_hold[s-1]) begin
            nc[s] = '0; nv[s] = 1'b0; nm[s] = 1'b0;
         end else begin
            nc[s] = m_ctrl[s-1]; nv[s] = m_valid[s-1]; nm[s] = m_mdu[s-1];
         end
      end
      if (reset || flush[0] || !m_hold[0]) age = 0;
      else if (age < 1000) age = age + 1;
      for (int s = 0; s < STAGES; s++) begin
         m_ctrl[s] = nc[s]; m_valid[s] = nv[s]; m_mdu[s] = nm[s];
      end
   endtask

   task automatic sample();
      logic [STAGES*CW-1:0] ec;
      logic [STAGES-1:0]    ev;
      #1;
      model_comb();
      for (int s = 0; s < STAGES; s++) begin
         ec[s*CW +: CW] = m_ctrl[s];
         ev[s]          = m_valid[s];
      end
      check("valid_o", valid_o, ev);
      check("ctrl_o", ctrl_o, ec);
      check("stall_req", stall_req, m_hold[0]);
      check("mdu_start", mdu_start, MDU_EN && m_valid[0] && m_mdu[0] && age == 0);
      check("mdu_busy", mdu_busy,
            MDU_EN && (MDU_LAT > 1) && m_valid[0] && m_mdu[0] && age >= 1 && age <= MDU_LAT - 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic m,
                        input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
      validD = v;
      ctrlD  = c;
      mduD   = m;
      stall  = st;
      flush  = fl;
   endtask

   initial begin
      logic [STAGES-1:0] st, fl;
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, '0);
      for (int s = 0; s < STAGES; s++) begin
         m_ctrl[s] = '0; m_valid[s] = 1'b0; m_mdu[s] = 1'b0;
      end
      age = 0;
      @(negedge clk);
      tick();

      // Reset state
      sample();
      check("rst_valid", valid_o, '0);
      check("rst_ctrl", ctrl_o, '0);
      tick();
      reset = 1'b0;

      // Single word walks E -> M -> W; junk on an invalid D must not follow it
      drive(1'b1, 12'h0A5, 1'b0, '0, '0);
      step();
      drive(1'b0, 12'hFFF, 1'b0, '0, '0);
      sample();
      check("walk_v0", valid_o, 3'b001);
      check("walk_c0", ctrl_o[11:0], 12'h0A5);
      tick();
      sample();
      check("walk_v1", valid_o, 3'b010);
      check("walk_c1", ctrl_o[23:12], 12'h0A5);
      tick();
      sample();
      check("walk_v2", valid_o, 3'b100);
      check("walk_c2", ctrl_o[35:24], 12'h0A5);
      tick();

      // stall[1] for two cycles with a stream in flight
      drive(1'b1, 12'h011, 1'b0, '0, '0); step();
      drive(1'b1, 12'h012, 1'b0, '0, '0); step();
      drive(1'b1, 12'h013, 1'b0, '0, '0); step();
      drive(1'b1, 12'h014, 1'b0, 3'b010, '0);
      sample();
      check("stl_req", stall_req, 1'b1);
      tick();
      sample();
      check("stl_valid", valid_o, 3'b011);
      check("stl_bubble_w", ctrl_o[35:24], 12'h000);
      check("stl_hold_e", ctrl_o[11:0], 12'h013);
      tick();
      drive(1'b1, 12'h015, 1'b0, '0, '0); step();
      drive(1'b0, '0, 1'b0, '0, '0);
      repeat (3) step();

      // Flush beats stall on stage 0
      drive(1'b1, 12'h03C, 1'b0, '0, '0); step();
      drive(1'b1, 12'h03D, 1'b0, 3'b001, 3'b001); step();
      drive(1'b0, '0, 1'b0, '0, '0);
      sample();
      check("flush_v0", valid_o[0], 1'b0);
      check("flush_c0", ctrl_o[11:0], 12'h000);
      tick();
      repeat (3) step();

      // MDU op, no external stalls
      drive(1'b1, 12'h0F0, 1'b1, '0, '0); step();
      drive(1'b0, '0, 1'b0, '0, '0);
      repeat (8) step();

      // MDU op with stall[1] held across the final count
      drive(1'b1, 12'h0F1, 1'b1, '0, '0); step();
      drive(1'b0, '0, 1'b0, 3'b010, '0);
      repeat (6) step();
      drive(1'b0, '0, 1'b0, '0, '0);
      repeat (4) step();

      // flush[0] on the second BUSY cycle
      drive(1'b1, 12'h0F2, 1'b1, '0, '0); step();
      drive(1'b0, '0, 1'b0, '0, '0); step(); step();
      drive(1'b0, '0, 1'b0, '0, 3'b001); step();
      drive(1'b0, '0, 1'b0, '0, '0);
      repeat (3) step();

      // Back-to-back MDU ops: D keeps presenting the second while F/D is frozen
      drive(1'b1, 12'h0F3, 1'b1, '0, '0); step();
      drive(1'b1, 12'h0F4, 1'b1, '0, '0);
      repeat (4) step();
      drive(1'b0, '0, 1'b0, '0, '0);
      repeat (8) step();

      // Reset in the middle of an MDU op
      drive(1'b1, 12'h0F5, 1'b1, '0, '0); step();
      drive(1'b0, '0, 1'b0, '0, '0); step(); step();
      reset = 1'b1; step();
      reset = 1'b0;
      repeat (3) step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         for (int s = 0; s < STAGES; s++) begin
            st[s] = ($urandom_range(0, 7) == 0);
            fl[s] = ($urandom_range(0, 15) == 0);
         end
         reset = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 2) == 0, st, fl);
         step();
      end
      reset = 1'b0;
      drive(1'b0, '0, 1'b0, '0, '0);
      repeat (8) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-word pipeline carrying decoded control from Decode through STAGES downstream stages (default E, M, W). Per-stage stall and flush, automatic bubble insertion, upstream stall propagation. Optional multicycle-unit (MDU) sequencer that holds a mult/div op in E for a fixed latency. Sits between the main/ALU decoders and the datapath; replaces hand-written per-stage control registers.

## Interface
- CW, 12, control-word width (memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol, ...)
- STAGES, 3, number of stages after D; index 0 = E, STAGES-1 = W
- MDU_LAT, 4, cycles an MDU op occupies stage 0; legal 1..16

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ctrlD  in  CW  decoded control word from D
- validD  in  1  D holds a real instruction
- mduD  in  1  D instruction is an MDU op
- stall  in  STAGES  per-stage stall request from hazard unit
- flush  in  STAGES  per-stage flush request from hazard unit
- ctrl_o  out  STAGES*CW  stage s word at bits [s*CW +: CW]
- valid_o  out  STAGES  per-stage valid
- stall_req  out  1  freeze F/D (equals hold[0])
- mdu_start  out  1  one-cycle pulse: MDU op begins in E
- mdu_busy  out  1  sequencer in BUSY

## Operation
- hold[s] = stall[s] | hold[s+1], with hold[STAGES] = 0; stage 0 also ORs mdu_stall.
- Per stage each edge, priority order: flush[s] -> load bubble; else hold[s] -> keep contents; else s = 0 -> load {ctrlD, validD, mduD}; else hold[s-1] -> load bubble; else load stage s-1.
- Bubble: valid 0, control word all zeros, mdu flag 0. validD = 0 loads equal a bubble (ctrl forced to 0).
- Flush beats stall on the same stage.
- MDU FSM states IDLE, BUSY, DONE; counter width $clog2(MDU_LAT), min 1.
  - mdu_stall = valid0 & mdu0 & (MDU_LAT > 1) & (state == IDLE | (state == BUSY & cnt != 0)).
  - IDLE: valid MDU op in stage 0 and MDU_LAT > 1 -> BUSY, cnt = MDU_LAT-2, mdu_start = 1.
  - BUSY: cnt decrements each cycle; at cnt = 0, mdu_stall drops; if hold[0] still set (external) -> DONE, else -> IDLE.
  - DONE: stay until stage 0 advances, then -> IDLE.
  - flush[0] in any state -> IDLE, cnt = 0 (op aborted).
- MDU_LAT = 1: no stall, mdu_start still pulses for one cycle when the op enters E.
- Back-to-back MDU ops: second enters E as FSM returns to IDLE and restarts normally.

## Timing
- Reset: all valid_o = 0, ctrl_o = 0, FSM IDLE, cnt = 0; stall_req and mdu_start = 0 except as driven combinationally by stall inputs.
- Latency D -> stage s: s+1 cycles when no holds.
- stall_req and mdu_stall are combinational from state and inputs, same cycle.
- An MDU op with no external stalls stays in E for exactly MDU_LAT cycles.
- Reset mid-MDU op clears pipeline and FSM in one edge.

## Configuration
- CTRL_PIPE_MDU_EN defined: MDU flag stored per stage, FSM and counter built, mdu_start/mdu_busy live.
- Undefined: mduD ignored, no FSM, mdu_stall = 0, mdu_start = mdu_busy = 0; pure stall/flush pipeline.

## Structure
- Package ctrl_pipe_pkg: mdu_state_t enum {IDLE, BUSY, DONE}, stage index constants (STG_E = 0, STG_M = 1, STG_W = 2), default CW.
- One sub-module ctrl_stage_reg: a single stage register with flush/hold/bubble/load select, generated STAGES times.

## Test plan
- Reset, then ctrlD = 12'h0A5 valid for 1 cycle -> appears at stage 0, 1, 2 on cycles 1, 2, 3; valid_o walks 001 -> 010 -> 100.
- stall = 3'b010 for 2 cycles with stream in flight -> stages 0, 1 hold, stall_req = 1, stage 2 receives bubbles (valid 0, ctrl 0).
- stall[0] and flush[0] both set -> stage 0 becomes bubble, not held.
- MDU op, MDU_LAT = 4 -> mdu_start pulse on entry, stall_req high 3 cycles, op reaches stage 1 on the 5th cycle after entering stage 0.
- MDU op with stall[1] held across cnt = 0 -> FSM enters DONE, no second mdu_start, IDLE after stage 0 advances.
- flush[0] at second BUSY cycle -> FSM IDLE, mdu_busy = 0, stage 0 bubble, stall_req drops next cycle.
